// File: rtl/reescalador_pkg.sv
// reescalador_pkg
// Shared types and constants for the reescalador controller, its qp divider
// and any reference model or sink that follows the rescaled stream.
//   state_t      controller FSM states
//   pos_class_t  coefficient position class inside a 4x4 block
//   sideband_t   per-coefficient sideband carried alongside the datapath
package reescalador_pkg;

  localparam int BLK_COEFS = 16;
  localparam int QP_MAX    = 51;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    POS_EVEN  = 2'd0,  // row and column both even
    POS_ODD   = 2'd1,  // row and column both odd
    POS_MIXED = 2'd2   // one even, one odd
  } pos_class_t;

  typedef struct packed {
    logic       last;
    logic       bypass;
    pos_class_t pos_class;
  } sideband_t;

  // Only the parity of row and column matters, so callers pass idx[2]
  // (row lsb) and idx[0] (column lsb) of the raster index.
  function automatic pos_class_t pos_class_of(input logic row_lsb,
                                              input logic col_lsb);
    if (!row_lsb && !col_lsb) begin
      return POS_EVEN;
    end else if (row_lsb && col_lsb) begin
      return POS_ODD;
    end else begin
      return POS_MIXED;
    end
  endfunction

endpackage

// File: rtl/reescalador_qpdiv.sv
// reescalador_qpdiv
// Iterative divide-by-6 of a 6-bit qp by repeated subtraction.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   start        load dividend and begin (one-cycle pulse)
//   dividend     qp to divide
//   done         combinational: result on quot/rem is final this cycle
//   quot         floor(dividend/6)
//   rem          dividend mod 6 (valid when done; always < 6 then)
// After start, done rises floor(dividend/6) cycles later (first busy cycle
// when the dividend is already below 6). A 6-bit input needs at most 11
// busy cycles and the quotient never exceeds 10, so 4 bits suffice.
module reescalador_qpdiv (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] dividend,
  output logic       done,
  output logic [3:0] quot,
  output logic [2:0] rem
);

  logic       busy_q, busy_d;
  logic [5:0] rem_q, rem_d;
  logic [3:0] quot_q, quot_d;

  always_comb begin
    busy_d = busy_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    done   = busy_q && (rem_q < 6'd6);
    if (start) begin
      busy_d = 1'b1;
      rem_d  = dividend;
      quot_d = 4'd0;
    end else if (busy_q) begin
      if (rem_q >= 6'd6) begin
        rem_d  = rem_q - 6'd6;
        quot_d = quot_q + 4'd1;
      end else begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      rem_q  <= 6'd0;
      quot_q <= 4'd0;
    end else begin
      busy_q <= busy_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q[2:0];

endmodule

// File: rtl/reescalador_ctrl.sv
// reescalador_ctrl
// Sequencing controller for the reescalador rescaler datapath. Takes one
// header (qp, skip_dc) per 4x4 block, divides qp by 6, then streams the 16
// raster-ordered coefficients into datapath stage 0 with sideband, and
// tracks valid/last through the DP_LAT-stage datapath so the rescaled
// output honours downstream backpressure.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   hdr_valid/ready         block header handshake; hdr_qp, hdr_skip_dc
//   coef_valid/ready        input coefficient handshake; coef_data
//   dp_en                   advance every datapath stage this cycle
//   dp_in_valid             stage 0 holds a real coefficient
//   dp_coef, dp_pos_class,
//   dp_bypass               stage-0 coefficient and its sideband
//   dp_qp_div6, dp_qp_mod6  current block's qp/6 and qp%6
//   out_valid/out_ready     datapath output handshake; out_last marks idx 15
//   dbg_state               current FSM state (state_t encoding)
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid, and a producer holds valid and
// data steady until the transfer.
module reescalador_ctrl
  import reescalador_pkg::*;
#(
  parameter int COEF_W = 16,
  parameter int DP_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              hdr_valid,
  output logic              hdr_ready,
  input  logic [5:0]        hdr_qp,
  input  logic              hdr_skip_dc,
  input  logic              coef_valid,
  output logic              coef_ready,
  input  logic [COEF_W-1:0] coef_data,
  output logic              dp_en,
  output logic              dp_in_valid,
  output logic [COEF_W-1:0] dp_coef,
  output logic [3:0]        dp_qp_div6,
  output logic [2:0]        dp_qp_mod6,
  output logic [1:0]        dp_pos_class,
  output logic              dp_bypass,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [1:0]        dbg_state
);

  state_t              state_q, state_d;
  logic                skip_dc_q, skip_dc_d;
  logic [3:0]          idx_q, idx_d;
  logic [3:0]          div6_q, div6_d;
  logic [2:0]          mod6_q, mod6_d;
  logic [COEF_W-1:0]   coef_q, coef_d;
  logic [1:0]          pos_q, pos_d;
  logic                byp_q, byp_d;
  logic [DP_LAT-1:0]   vld_q, vld_d;
  logic [DP_LAT-1:0]   last_q, last_d;

  logic                qd_start;
  logic                qd_done;
  logic [3:0]          qd_quot;
  logic [2:0]          qd_rem;
  logic                accept;
  sideband_t           sb;

  reescalador_qpdiv u_qpdiv (
    .clk      (clk),
    .reset    (reset),
    .start    (qd_start),
    .dividend (hdr_qp),
    .done     (qd_done),
    .quot     (qd_quot),
    .rem      (qd_rem)
  );

  // The whole pipeline stalls only when the output stage is full and the
  // consumer refuses it; there are no internal bubbles to squeeze out.
  assign out_valid = vld_q[DP_LAT-1];
  assign dp_en     = !(out_valid && !out_ready);

  always_comb begin
    state_d      = state_q;
    skip_dc_d    = skip_dc_q;
    idx_d        = idx_q;
    div6_d       = div6_q;
    mod6_d       = mod6_q;
    coef_d       = coef_q;
    pos_d        = pos_q;
    byp_d        = byp_q;
    vld_d        = vld_q;
    last_d       = last_q;
    qd_start     = 1'b0;
    hdr_ready    = 1'b0;
    coef_ready   = 1'b0;
    accept       = 1'b0;
    sb.pos_class = pos_class_of(idx_q[2], idx_q[0]);
    sb.bypass    = skip_dc_q && (idx_q == 4'd0);
    sb.last      = (idx_q == 4'(BLK_COEFS - 1));

    case (state_q)
      ST_IDLE: begin
        hdr_ready = 1'b1;
        if (hdr_valid) begin
          qd_start  = 1'b1;
          skip_dc_d = hdr_skip_dc;
          state_d   = ST_DIV;
        end
      end
      ST_DIV: begin
        if (qd_done) begin
          div6_d  = qd_quot;
          mod6_d  = qd_rem;
          idx_d   = 4'd0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        coef_ready = dp_en;
        accept     = coef_valid && dp_en;
        if (accept) begin
          idx_d = idx_q + 4'd1;
          if (sb.last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      default: begin
      end
    endcase

    if (dp_en) begin
      for (int i = DP_LAT - 1; i >= 1; i--) begin
        vld_d[i]  = vld_q[i-1];
        last_d[i] = last_q[i-1];
      end
      vld_d[0]  = accept;
      last_d[0] = accept && sb.last;
      if (accept) begin
        coef_d = coef_data;
        pos_d  = sb.pos_class;
        byp_d  = sb.bypass;
      end
    end

    // Leave DRAIN on the edge that shifts the final valid out, so the
    // pipeline is already empty in the first IDLE cycle.
    if ((state_q == ST_DRAIN) && (vld_d == '0)) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      skip_dc_q <= 1'b0;
      idx_q     <= 4'd0;
      div6_q    <= 4'd0;
      mod6_q    <= 3'd0;
      coef_q    <= '0;
      pos_q     <= 2'd0;
      byp_q     <= 1'b0;
      vld_q     <= '0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      skip_dc_q <= skip_dc_d;
      idx_q     <= idx_d;
      div6_q    <= div6_d;
      mod6_q    <= mod6_d;
      coef_q    <= coef_d;
      pos_q     <= pos_d;
      byp_q     <= byp_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
    end
  end

  assign dp_in_valid  = vld_q[0];
  assign dp_coef      = coef_q;
  assign dp_qp_div6   = div6_q;
  assign dp_qp_mod6   = mod6_q;
  assign dp_pos_class = pos_q;
  assign dp_bypass    = byp_q;
  assign out_last     = last_q[DP_LAT-1] && out_valid;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_reescalador_ctrl.sv
module tb_reescalador_ctrl;

  localparam int COEF_W = 16;
  localparam int DP_LAT = 2;

  // clock / reset / DUT signals
  logic              clk;
  logic              reset;
  logic              hdr_valid;
  logic              hdr_ready;
  logic [5:0]        hdr_qp;
  logic              hdr_skip_dc;
  logic              coef_valid;
  logic              coef_ready;
  logic [COEF_W-1:0] coef_data;
  logic              dp_en;
  logic              dp_in_valid;
  logic [COEF_W-1:0] dp_coef;
  logic [3:0]        dp_qp_div6;
  logic [2:0]        dp_qp_mod6;
  logic [1:0]        dp_pos_class;
  logic              dp_bypass;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_hdr = 0;
  int hdr_seen = 0;
  int exp_hdr = 0;

  // scoreboard queues: stage-0 {coef, pos, bypass, div6, mod6} and output {last, coef}
  logic [25:0] s0_q[$];
  logic [16:0] out_q[$];
  logic [1:0]  pos_tbl[16];
  logic [COEF_W-1:0] stage1;

  reescalador_ctrl #(.COEF_W(COEF_W), .DP_LAT(DP_LAT)) dut (
    .clk          (clk),
    .reset        (reset),
    .hdr_valid    (hdr_valid),
    .hdr_ready    (hdr_ready),
    .hdr_qp       (hdr_qp),
    .hdr_skip_dc  (hdr_skip_dc),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .coef_data    (coef_data),
    .dp_en        (dp_en),
    .dp_in_valid  (dp_in_valid),
    .dp_coef      (dp_coef),
    .dp_qp_div6   (dp_qp_div6),
    .dp_qp_mod6   (dp_qp_mod6),
    .dp_pos_class (dp_pos_class),
    .dp_bypass    (dp_bypass),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .dbg_state    (dbg_state)
  );

  // clock block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in for the one datapath stage after stage 0
  always @(posedge clk) begin
    if (reset) stage1 <= '0;
    else if (dp_en) stage1 <= dp_coef;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout (t=%0t)", name, $time);
  endtask

  // monitor
  always @(negedge clk) begin
    if (!reset) begin
      if (hdr_valid && hdr_ready) hdr_seen++;
      if (out_valid && !out_ready) chk("coef_ready_stall", {31'd0, coef_ready}, 32'd0);
      if (out_last) chk("out_last_gated", {31'd0, out_valid}, 32'd1);
      if (dp_in_valid && dp_en) begin
        if (s0_q.size() == 0) timeout("stage0_unexpected");
        else chk("stage0", {6'd0, dp_coef, dp_pos_class, dp_bypass, dp_qp_div6, dp_qp_mod6},
                 {6'd0, s0_q.pop_front()});
      end
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) timeout("output_unexpected");
        else chk("output", {15'd0, out_last, stage1}, {15'd0, out_q.pop_front()});
      end
    end
  end

  // driver tasks: entered and left at posedge+1
  task automatic do_header(input logic [5:0] qp, input logic skip, input bit hold);
    int n;
    hdr_qp = qp;
    hdr_skip_dc = skip;
    hdr_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (hdr_ready) break;
      n++;
      if (n > 500) begin
        timeout("hdr_wait");
        break;
      end
    end
    t_hdr = cyc;
    exp_hdr++;
    @(posedge clk);
    #1;
    if (!hold) hdr_valid = 1'b0;
  endtask

  task automatic send_coefs(input logic [COEF_W-1:0] base, input int n_coefs,
                            input logic skip, input logic [3:0] div6,
                            input logic [2:0] mod6, input int gap);
    int n;
    logic [COEF_W-1:0] d;
    for (int i = 0; i < n_coefs; i++) begin
      d = base + COEF_W'(i);
      coef_valid = 1'b1;
      coef_data = d;
      n = 0;
      forever begin
        @(negedge clk);
        if (coef_ready) break;
        n++;
        if (n > 500) begin
          timeout("coef_wait");
          break;
        end
      end
      if (i == 0) chk("run_latency", cyc - t_hdr, 32'(div6) + 32'd2);
      s0_q.push_back({d, pos_tbl[i], skip && (i == 0), div6, mod6});
      out_q.push_back({i == 15, d});
      @(posedge clk);
      #1;
      if (gap != 0 && (i % gap) == gap - 1) begin
        coef_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    coef_valid = 1'b0;
  endtask

  initial begin
    int t_prev;
    int n;
    pos_tbl = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1,
                2'd0, 2'd2, 2'd0, 2'd2, 2'd2, 2'd1, 2'd2, 2'd1};
    reset = 1'b1;
    hdr_valid = 1'b0;
    hdr_qp = 6'd0;
    hdr_skip_dc = 1'b0;
    coef_valid = 1'b0;
    coef_data = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_hdr_ready", {31'd0, hdr_ready}, 32'd1);
    chk("rst_coef_ready", {31'd0, coef_ready}, 32'd0);
    chk("rst_dp_en", {31'd0, dp_en}, 32'd1);
    chk("rst_dp_in_valid", {31'd0, dp_in_valid}, 32'd0);
    chk("rst_dp_coef", {16'd0, dp_coef}, 32'd0);
    chk("rst_div6", {28'd0, dp_qp_div6}, 32'd0);
    chk("rst_mod6", {29'd0, dp_qp_mod6}, 32'd0);
    chk("rst_pos", {30'd0, dp_pos_class}, 32'd0);
    chk("rst_bypass", {31'd0, dp_bypass}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk);
    #1;

    // qp=0, coefficients 1..16
    do_header(6'd0, 1'b0, 1'b0);
    send_coefs(16'd1, 16, 1'b0, 4'd0, 3'd0, 0);

    // qp=51 -> 8 r 3, first coef_ready 10 cycles after the header
    do_header(6'd51, 1'b0, 1'b0);
    send_coefs(16'h0100, 16, 1'b0, 4'd8, 3'd3, 0);

    // qp=28, skip_dc -> 4 r 4, bypass on idx 0 only; input gaps
    do_header(6'd28, 1'b1, 1'b0);
    send_coefs(16'hA000, 16, 1'b1, 4'd4, 3'd4, 3);

    // qp=13 -> 2 r 1, 5-cycle output stall mid-stream
    do_header(6'd13, 1'b0, 1'b0);
    fork
      send_coefs(16'h0200, 16, 1'b0, 4'd2, 3'd1, 0);
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join

    // reset after 7 coefficients, then a clean qp=12 block
    do_header(6'd40, 1'b0, 1'b0);
    send_coefs(16'h0700, 7, 1'b0, 4'd6, 3'd4, 0);
    reset = 1'b1;
    s0_q.delete();
    out_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_hdr_ready", {31'd0, hdr_ready}, 32'd1);
    chk("mid_rst_dp_in_valid", {31'd0, dp_in_valid}, 32'd0);
    chk("mid_rst_div6", {28'd0, dp_qp_div6}, 32'd0);
    @(posedge clk);
    #1;
    do_header(6'd12, 1'b0, 1'b0);
    send_coefs(16'h0300, 16, 1'b0, 4'd2, 3'd0, 0);

    // back-to-back headers with hdr_valid held high
    do_header(6'd0, 1'b0, 1'b1);
    t_prev = t_hdr;
    send_coefs(16'h0400, 16, 1'b0, 4'd0, 3'd0, 0);
    do_header(6'd6, 1'b0, 1'b0);
    chk("hdr_return", t_hdr - t_prev, 32'd20);
    send_coefs(16'h0500, 16, 1'b0, 4'd1, 3'd0, 0);

    n = 0;
    while ((s0_q.size() != 0 || out_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("s0_q_empty", s0_q.size(), 32'd0);
    chk("out_q_empty", out_q.size(), 32'd0);
    chk("hdr_count", hdr_seen, exp_hdr);
    chk("final_idle", {30'd0, dbg_state}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reescalador_ctrl.md
# reescalador_ctrl

Sequencing controller for the reescalador (inverse-quantisation rescaler) datapath. It accepts a per-block header carrying QP and a DC-bypass flag, and derives qp/6 and qp%6 with an iterative subtractor. It then streams 16 raster-ordered coefficients of one 4x4 block into the datapath with per-coefficient sideband (position class, bypass, last). It also owns the datapath pipeline enable and output valid tracking, so the rescaled stream honours downstream backpressure.

## Interface
- COEF_W, 16, coefficient width in and out of datapath
- DP_LAT, 2, datapath pipeline depth in stages (≥1)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, one reset domain
- hdr_valid  in  1  block header valid
- hdr_ready  out  1  header accepted when valid&ready
- hdr_qp  in  6  quantisation parameter, legal 0..51
- hdr_skip_dc  in  1  coefficient 0 bypasses scaling (DC handled elsewhere)
- coef_valid  in  1  input coefficient valid
- coef_ready  out  1  input coefficient accepted when valid&ready
- coef_data  in  COEF_W  input coefficient, raster order idx 0..15
- dp_en  out  1  advance datapath pipeline by one stage
- dp_in_valid  out  1  stage-0 contents are a real coefficient
- dp_coef  out  COEF_W  coefficient to datapath (registered coef_data)
- dp_qp_div6  out  4  floor(qp/6)
- dp_qp_mod6  out  3  qp mod 6
- dp_pos_class  out  2  0: row,col both even; 1: both odd; 2: mixed
- dp_bypass  out  1  pass coefficient unscaled
- out_valid  out  1  datapath output holds a valid rescaled coefficient
- out_ready  in  1  downstream accepts
- out_last  out  1  marks coefficient 15 of the block at output

## Operation
- States: IDLE, DIV, RUN, DRAIN.
- IDLE: hdr_ready=1, coef_ready=0. On hdr_valid: latch qp into rem, quot=0, and latch skip_dc. Go to DIV.
- DIV: each cycle, if rem≥6 then rem-=6 and quot+=1; else load dp_qp_div6=quot and dp_qp_mod6=rem[2:0], set idx=0, go RUN. The state lasts floor(qp/6)+1 cycles.
- RUN: coef_ready=dp_en. On each accept, coef_data and sideband enter stage 0 and idx increments.
  - pos_class uses row=idx[3:2], col=idx[1:0].
  - bypass = skip_dc & (idx==0).
  - last = (idx==15).
  - Accepting idx 15 moves the FSM to DRAIN.
- DRAIN: no input accepted. Go IDLE once all valid bits are clear.
- Valid tracking: DP_LAT-bit shift register vld[] plus a matching last[] shift register, both advanced only when dp_en=1.
  - vld[0] = coefficient accepted this cycle.
  - out_valid = vld[DP_LAT-1]; out_last = last[DP_LAT-1] & out_valid.
- dp_en = !(out_valid & !out_ready). A bubble-free pipeline stalls entirely on backpressure.
- dp_qp_div6 and dp_qp_mod6 hold steady from the DIV→RUN transition until the next header is accepted.
- qp>51 is out of range. The divider still terminates (max 11 cycles) and the result is unspecified-but-bounded.

## Timing
- Reset values:
  - state=IDLE, hdr_ready=1, coef_ready=0, dp_en=1, dp_in_valid=0, dp_coef=0.
  - dp_qp_div6=0, dp_qp_mod6=0, dp_pos_class=0, dp_bypass=0.
  - out_valid=0, out_last=0, all vld/last bits 0.
- Header accepted at cycle T. RUN is entered at T+floor(qp/6)+2 and coef_ready can first be high then.
- A coefficient accepted at cycle C appears with out_valid at C+DP_LAT, assuming no stall.
- With no stalls, a block occupies floor(qp/6)+2+16+DP_LAT cycles before hdr_ready returns.
- Backpressure: out_ready=0 while out_valid=1 forces coef_ready=0 and freezes vld, last and the datapath in the same cycle. Nothing is dropped or duplicated.
- coef_valid gaps in RUN insert bubbles (vld[0]=0). idx does not advance.
- Simultaneous events:
  - hdr_valid during DIV/RUN/DRAIN is not accepted (hdr_ready=0).
  - coef_valid outside RUN is ignored.
- Reset mid-block: everything returns to reset values next cycle. The partial block is discarded and no out_last is emitted for it.

## Structure
- Shared package reescalador_pkg holds:
  - the state enum;
  - constants BLK_COEFS=16, QP_MAX=51;
  - the pos_class enum;
  - the struct grouping pipeline sideband (last, bypass, pos_class). The refmod and sink reuse it.
- One natural sub-module, reescalador_qpdiv: iterative divide-by-6 with start/done handshake, used by the DIV state.

## Test plan
- qp=0, no stalls, coefficients 1..16, skip_dc=0 -> div6=0, mod6=0, DIV 1 cycle; 16 outputs, out_last only on the 16th; pos_class sequence 0,2,0,2,2,1,2,1,…
- qp=51 -> div6=8, mod6=3, DIV lasts 9 cycles; first coef_ready at T+10.
- qp=28, skip_dc=1 -> div6=4, mod6=4; dp_bypass=1 only for idx 0.
- out_ready low for 5 cycles while a block is mid-stream -> coef_ready=0 those cycles; output sequence and out_last unchanged against the refmod; no losses.
- reset asserted after 7 coefficients accepted -> next cycle IDLE and out_valid=0; the next block with qp=12 produces a clean 16-coefficient run with div6=2, mod6=0.
- Back-to-back headers with hdr_valid held high -> the second header is accepted only after DRAIN empties. Exactly one hdr_ready pulse per block.
